sdram_init_refresh_ctrl: RTL and testbench
==========================================

// Module: sdram_init_refresh_ctrl
// PURPOSE
//  Parametrised SDRAM power-up sequencer and periodic refresh engine. After reset it performs the
//  JEDEC init: power-up wait, PRECHARGE-all, N AUTO-REFRESH, LOAD MODE. It then raises complete.
//  With SDRAM_AUTO_REFRESH_EN it keeps issuing timed refreshes through a req/ack handshake.
//  It sits beside the read/write controller; the memory arbiter muxes the DRAM pins using bus_own.
// PARAMETERS
//  T_POWERUP   20000  cycles of NOP before the first command (CKE high, DQM high)
//  T_RP        3      PRECHARGE-to-next-command cycles
//  T_RC        9      REFRESH-to-next-command cycles
//  T_MRD       2      LOAD MODE-to-complete cycles
//  INIT_REFS   8      AUTO-REFRESH commands in the init sequence (1..255)
//  CAS_LAT     2      mode register CAS latency (2 or 3)
//  BL_CODE     3'b001 mode register burst-length field
//  T_REFI      780    refresh interval in cycles (periodic refresh only)
//  ADDR_W      13     DRAM address width
// PORTS
//  clk         in  1      system clock
//  reset       in  1      asynchronous, active-high reset
//  complete    out 1      init finished; held high until reset
//  bus_own     out 1      block is driving DRAM pins (init, or refresh after ack)
//  ref_req     out 1      periodic refresh pending; held until ref_ack
//  ref_ack     in  1      arbiter grant: all banks idle, pins handed to this block
//  ref_done    out 1      one-cycle pulse at the end of a granted refresh
//  ref_ovf     out 1      sticky: refresh debt saturated (missed deadline)
//  DRAM_CKE, DRAM_CS_N  out 1  tied 1 / 0
//  DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N  out 1  command {RAS,CAS,WE}
//  DRAM_LDQM, DRAM_UDQM out 1  both high while bus_own
//  DRAM_ADDR   out ADDR_W  address / mode word
//  DRAM_BA     out 2       bank address
// BEHAVIOUR
//  Reset: complete=0, bus_own=1, ref_req=0, ref_done=0, ref_ovf=0, cmd=NOP(111), DQM=11,
//   ADDR=0, BA=0, state=WAIT, counters=0. Reset mid-operation aborts and restarts from WAIT.
//  Commands are registered and last exactly one cycle; every other cycle is NOP.
//  Init FSM: WAIT (T_POWERUP cycles) -> PRE (PRECHARGE, ADDR[10]=1, BA=0) -> PRE_W (T_RP-1 NOP)
//   -> REF (REFRESH) -> REF_W (T_RC-1 NOP); loop INIT_REFS times -> MRS (LOADMODE, BA=0,
//   ADDR={000,0,00,CAS_LAT[2:0],0,BL_CODE}) -> MRS_W (T_MRD-1 NOP) -> IDLE: complete=1, bus_own=0.
//  Example: CAS_LAT=2, BL_CODE=1 gives ADDR=13'h0021.
//  Refresh scheduler (macro only): the interval counter starts at IDLE entry and fires every
//   T_REFI cycles. The 3-bit debt counter increments on fire, decrements on ref_done, and holds
//   when both happen in the same cycle. ref_req = (debt!=0). A fire at debt=7 saturates it and sets ref_ovf.
//  Refresh FSM: IDLE & ref_req & ref_ack -> R_PRE (bus_own=1, PRECHARGE-all) -> R_PRE_W (T_RP-1)
//   -> R_REF (REFRESH) -> R_REF_W (T_RC-1) -> IDLE with ref_done=1 for 1 cycle, bus_own=0.
//   ref_ack is ignored outside IDLE and when ref_req=0.
// CONFIGURATION
//  SDRAM_AUTO_REFRESH_EN defined: the scheduler and refresh FSM are built as above.
//  Not defined: the block stays in IDLE after init. ref_req, ref_done and ref_ovf are tied 0.
//   ref_ack is unused and bus_own stays 0 after complete.
// STRUCTURE
//  Shared package sdram_pkg (sdram.h): DRAM_CMD_NOP/PRECHARGE/REFRESH/LOADMODE encodings and the
//   mode-word field offsets. The state enum stays local.
//  Sub-module sdram_refresh_timer: interval counter plus debt counter, outputs ref_req and ref_ovf.
// TESTING (sim params: T_POWERUP=20, INIT_REFS=2, T_REFI=50)
//  1 Release reset -> 20 NOP cycles, then PRECHARGE with ADDR[10]=1; next command exactly T_RP later.
//  2 Init completes -> exactly 2 REFRESH spaced T_RC apart, LOADMODE ADDR=0x021, complete T_MRD later.
//  3 ref_ack tied high -> refresh at 50-cycle cadence; PRECHARGE then REFRESH; ref_done once each.
//  4 ref_ack held low 400 cycles -> debt reaches 7, ref_ovf=1; then ack -> 7 ref_done, ref_req falls.
//  5 Fire in the same cycle as ref_done -> debt unchanged, ref_req stays high.
//  6 Reset asserted in REF_W and at random points -> outputs return to reset values and the sequence restarts.

Source files
------------

// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: command encodings {RAS_N,CAS_N,WE_N}, mode-word field offsets
// and small elaboration helpers used by the init/refresh controller.
package sdram_pkg;

  typedef logic [2:0] dram_cmd_t;

  localparam dram_cmd_t DRAM_CMD_NOP       = 3'b111;
  localparam dram_cmd_t DRAM_CMD_PRECHARGE = 3'b010;
  localparam dram_cmd_t DRAM_CMD_REFRESH   = 3'b001;
  localparam dram_cmd_t DRAM_CMD_LOADMODE  = 3'b000;

  // Mode register layout: [2:0] burst length, [3] burst type, [6:4] CAS latency,
  // [8:7] operating mode, [9] write burst mode. A10 selects all banks for PRECHARGE.
  localparam int MODE_BL_LSB  = 0;
  localparam int MODE_CAS_LSB = 4;
  localparam int A10_BIT      = 10;

  function automatic logic [12:0] mode_word(input logic [2:0] cas, input logic [2:0] bl);
    logic [12:0] w;
    w = '0;
    w[MODE_CAS_LSB +: 3] = cas;
    w[MODE_BL_LSB +: 3]  = bl;
    return w;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sdram_refresh_timer.sv
// Refresh interval counter plus 3-bit refresh debt; ref_req while any debt is owed,
// ref_ovf latches when an interval expires with the debt already saturated.
module sdram_refresh_timer
  import sdram_pkg::*;
#(
  parameter int T_REFI = 780
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic done,
  output logic ref_req,
  output logic ref_ovf
);

  localparam int CW = $clog2(T_REFI + 1);

  logic [CW-1:0] cnt_q;
  logic [2:0]    debt_q;
  logic          ovf_q;
  logic          fire;

  assign fire = en && (cnt_q == CW'(T_REFI - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      debt_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (!en || fire) cnt_q <= '0;
      else             cnt_q <= cnt_q + 1'b1;

      // A fire and a completed refresh in the same cycle cancel out.
      case ({fire, done})
        2'b10: begin
          if (debt_q == 3'd7) ovf_q  <= 1'b1;
          else                debt_q <= debt_q + 3'd1;
        end
        2'b01: begin
          if (debt_q != 3'd0) debt_q <= debt_q - 3'd1;
        end
        default: ;
      endcase
    end
  end

  assign ref_req = (debt_q != 3'd0);
  assign ref_ovf = ovf_q;

endmodule

// File: rtl/sdram_init_refresh_ctrl.sv
// SDRAM power-up sequencer (wait, PRECHARGE-all, N x REFRESH, LOAD MODE) with optional
// periodic refresh engine enabled by the SDRAM_AUTO_REFRESH_EN macro.
module sdram_init_refresh_ctrl
  import sdram_pkg::*;
#(
  parameter int         T_POWERUP = 20000,
  parameter int         T_RP      = 3,
  parameter int         T_RC      = 9,
  parameter int         T_MRD     = 2,
  parameter int         INIT_REFS = 8,
  parameter int         CAS_LAT   = 2,
  parameter logic [2:0] BL_CODE   = 3'b001,
  parameter int         T_REFI    = 780,
  parameter int         ADDR_W    = 13
) (
  input  logic              clk,
  input  logic              reset,
  output logic              complete,
  output logic              bus_own,
  output logic              ref_req,
  input  logic              ref_ack,
  output logic              ref_done,
  output logic              ref_ovf,
  output logic              DRAM_CKE,
  output logic              DRAM_CS_N,
  output logic              DRAM_RAS_N,
  output logic              DRAM_CAS_N,
  output logic              DRAM_WE_N,
  output logic              DRAM_LDQM,
  output logic              DRAM_UDQM,
  output logic [ADDR_W-1:0] DRAM_ADDR,
  output logic [1:0]        DRAM_BA,
  output logic [3:0]        dbg_state
);

  typedef enum logic [3:0] {
    S_WAIT, S_PRE, S_PRE_W, S_REF, S_REF_W, S_MRS, S_MRS_W, S_IDLE,
    S_R_PRE, S_R_PRE_W, S_R_REF, S_R_REF_W
  } state_t;

  // Wait states reuse one counter; T_RP, T_RC and T_MRD must be at least 2.
  localparam int MAX_T = max_int(max_int(T_POWERUP, T_RP), max_int(T_RC, T_MRD));
  localparam int CNT_W = $clog2(MAX_T + 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [7:0]        refs_q, refs_d;
  dram_cmd_t         cmd_q, cmd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              bus_own_q, bus_own_d;
  logic              complete_q;
  logic              done_d;

  always_comb begin
    state_d = state_q;
    refs_d  = refs_q;
    done_d  = 1'b0;
    case (state_q)
      S_WAIT:  if (cnt_q == CNT_W'(T_POWERUP - 1)) state_d = S_PRE;
      S_PRE:   state_d = S_PRE_W;
      S_PRE_W: if (cnt_q == CNT_W'(T_RP - 2)) state_d = S_REF;
      S_REF:   state_d = S_REF_W;
      S_REF_W: begin
        if (cnt_q == CNT_W'(T_RC - 2)) begin
          refs_d  = refs_q + 8'd1;
          state_d = (refs_q == 8'(INIT_REFS - 1)) ? S_MRS : S_REF;
        end
      end
      S_MRS:   state_d = S_MRS_W;
      S_MRS_W: if (cnt_q == CNT_W'(T_MRD - 2)) state_d = S_IDLE;
`ifdef SDRAM_AUTO_REFRESH_EN
      // The done cycle is skipped so debt is already decremented before the next grant.
      S_IDLE:  if (ref_req && ref_ack && !ref_done) state_d = S_R_PRE;
      S_R_PRE:   state_d = S_R_PRE_W;
      S_R_PRE_W: if (cnt_q == CNT_W'(T_RP - 2)) state_d = S_R_REF;
      S_R_REF:   state_d = S_R_REF_W;
      S_R_REF_W: begin
        if (cnt_q == CNT_W'(T_RC - 2)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
`else
      S_IDLE:  state_d = S_IDLE;
`endif
      default: state_d = S_WAIT;
    endcase

    if (state_d != state_q)   cnt_d = '0;
    else if (state_q == S_IDLE) cnt_d = cnt_q;
    else                       cnt_d = cnt_q + 1'b1;
  end

  // Pin values are decoded from the next state so every command lasts exactly one cycle.
  always_comb begin
    cmd_d     = DRAM_CMD_NOP;
    addr_d    = '0;
    bus_own_d = (state_d != S_IDLE);
    case (state_d)
      S_PRE, S_R_PRE: begin
        cmd_d           = DRAM_CMD_PRECHARGE;
        addr_d[A10_BIT] = 1'b1;
      end
      S_REF, S_R_REF: cmd_d = DRAM_CMD_REFRESH;
      S_MRS: begin
        cmd_d  = DRAM_CMD_LOADMODE;
        addr_d = ADDR_W'(mode_word(3'(CAS_LAT), BL_CODE));
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_WAIT;
      cnt_q      <= '0;
      refs_q     <= '0;
      cmd_q      <= DRAM_CMD_NOP;
      addr_q     <= '0;
      bus_own_q  <= 1'b1;
      complete_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      refs_q     <= refs_d;
      cmd_q      <= cmd_d;
      addr_q     <= addr_d;
      bus_own_q  <= bus_own_d;
      complete_q <= complete_q | (state_d == S_IDLE);
    end
  end

`ifdef SDRAM_AUTO_REFRESH_EN
  logic ref_done_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ref_done_q <= 1'b0;
    else       ref_done_q <= done_d;
  end

  assign ref_done = ref_done_q;

  sdram_refresh_timer #(
    .T_REFI (T_REFI)
  ) u_refresh_timer (
    .clk     (clk),
    .reset   (reset),
    .en      (complete_q),
    .done    (ref_done_q),
    .ref_req (ref_req),
    .ref_ovf (ref_ovf)
  );
`else
  logic unused_cfg;

  assign unused_cfg = ref_ack ^ done_d ^ T_REFI[0];
  assign ref_req    = 1'b0;
  assign ref_done   = 1'b0;
  assign ref_ovf    = 1'b0;
`endif

  assign complete   = complete_q;
  assign bus_own    = bus_own_q;
  assign DRAM_CKE   = 1'b1;
  assign DRAM_CS_N  = 1'b0;
  assign DRAM_RAS_N = cmd_q[2];
  assign DRAM_CAS_N = cmd_q[1];
  assign DRAM_WE_N  = cmd_q[0];
  assign DRAM_LDQM  = bus_own_q;
  assign DRAM_UDQM  = bus_own_q;
  assign DRAM_ADDR  = addr_q;
  assign DRAM_BA    = 2'b00;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_sdram_init_refresh_ctrl.sv
// Bench for sdram_init_refresh_ctrl: timestamped command schedule plus a refresh-debt model,
// randomized ack and reset stimulus.
module tb_sdram_init_refresh_ctrl;

  localparam int T_POWERUP = 20;
  localparam int T_RP      = 3;
  localparam int T_RC      = 9;
  localparam int T_MRD     = 2;
  localparam int INIT_REFS = 2;
  localparam int T_REFI    = 50;
  localparam int ADDR_W    = 13;

  localparam int T_MRS  = T_POWERUP + T_RP + INIT_REFS * T_RC;
  localparam int T_DONE = T_MRS + T_MRD;
  localparam int T_RBUSY = T_RP + T_RC;

  localparam logic [2:0]  C_NOP  = 3'b111;
  localparam logic [2:0]  C_PRE  = 3'b010;
  localparam logic [2:0]  C_REF  = 3'b001;
  localparam logic [2:0]  C_MRS  = 3'b000;
  localparam logic [12:0] A_ALL  = 13'h0400;
  localparam logic [12:0] A_MODE = 13'h0021;

  logic clk, reset, ref_ack;
  logic complete, bus_own, ref_req, ref_done, ref_ovf;
  logic dram_cke, dram_cs_n, dram_ras_n, dram_cas_n, dram_we_n, dram_ldqm, dram_udqm;
  logic [ADDR_W-1:0] dram_addr;
  logic [1:0] dram_ba;
  logic [3:0] dbg_state_unused;

  sdram_init_refresh_ctrl #(
    .T_POWERUP (T_POWERUP), .T_RP (T_RP), .T_RC (T_RC), .T_MRD (T_MRD),
    .INIT_REFS (INIT_REFS), .CAS_LAT (2), .BL_CODE (3'b001), .T_REFI (T_REFI), .ADDR_W (ADDR_W)
  ) dut (
    .clk (clk), .reset (reset), .complete (complete), .bus_own (bus_own),
    .ref_req (ref_req), .ref_ack (ref_ack), .ref_done (ref_done), .ref_ovf (ref_ovf),
    .DRAM_CKE (dram_cke), .DRAM_CS_N (dram_cs_n), .DRAM_RAS_N (dram_ras_n),
    .DRAM_CAS_N (dram_cas_n), .DRAM_WE_N (dram_we_n), .DRAM_LDQM (dram_ldqm),
    .DRAM_UDQM (dram_udqm), .DRAM_ADDR (dram_addr), .DRAM_BA (dram_ba),
    .dbg_state (dbg_state_unused)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s n=%0d got=0x%0h exp=0x%0h", tag, n, got, exp);
    end
  endtask

  // scoreboard: expected non-NOP commands as {cycle[15:0], cmd[2:0], addr[12:0]}
  logic [31:0] exp_q[$];
  logic [31:0] exp_word;

  function automatic void push_cmd(input int cyc, input logic [2:0] c, input logic [12:0] a);
    logic [15:0] stamp;
    stamp = 16'(cyc);
    exp_q.push_back({stamp, c, a});
  endfunction

  // reference model state
  int n = 0;
  int debt = 0;
  int debt_prev;
  bit ovf = 1'b0;
  int g = -1;
  bit done_prev = 1'b0;
  bit exp_done, exp_bus, in_ref, inc, dec, idle_prev;

  always @(negedge clk) begin
    if (reset) begin
      check("rst_complete", complete, 0);
      check("rst_bus_own", bus_own, 1);
      check("rst_ref_req", ref_req, 0);
      check("rst_ref_done", ref_done, 0);
      check("rst_ref_ovf", ref_ovf, 0);
      check("rst_cmd", {dram_ras_n, dram_cas_n, dram_we_n}, C_NOP);
      check("rst_dqm", {dram_ldqm, dram_udqm}, 2'b11);
      check("rst_addr", dram_addr, 0);
      check("rst_ba", dram_ba, 0);
      n = 0; debt = 0; ovf = 1'b0; g = -1; done_prev = 1'b0;
      exp_q.delete();
      push_cmd(T_POWERUP, C_PRE, A_ALL);
      for (int i = 0; i < INIT_REFS; i++) push_cmd(T_POWERUP + T_RP + i * T_RC, C_REF, 13'h0);
      push_cmd(T_MRS, C_MRS, A_MODE);
    end else begin
      n++;
      exp_done = 1'b0;
      in_ref   = 1'b0;
`ifdef SDRAM_AUTO_REFRESH_EN
      debt_prev = debt;
      inc = (n > T_DONE) && ((n - T_DONE) % T_REFI == 0);
      dec = done_prev;
      if (inc && !dec) begin
        if (debt == 7) ovf = 1'b1;
        else           debt++;
      end else if (dec && !inc && debt > 0) begin
        debt--;
      end
      idle_prev = (n - 1 >= T_DONE) && !(g >= 0 && n - 1 >= g && n - 1 < g + T_RBUSY);
      if (idle_prev && debt_prev != 0 && ref_ack && !done_prev) begin
        g = n;
        push_cmd(g, C_PRE, A_ALL);
        push_cmd(g + T_RP, C_REF, 13'h0);
      end
      exp_done = (g >= 0) && (n == g + T_RBUSY);
      in_ref   = (g >= 0) && (n >= g) && (n < g + T_RBUSY);
`endif
      exp_bus = (n < T_DONE) || in_ref;
      if (exp_q.size() > 0 && exp_q[0][31:16] == 16'(n)) exp_word = exp_q.pop_front();
      else exp_word = {16'(n), C_NOP, 13'h0};
      check("cmd_addr", {dram_ras_n, dram_cas_n, dram_we_n, dram_addr}, {16'h0, exp_word[15:0]});
      check("complete", complete, (n >= T_DONE) ? 1 : 0);
      check("bus_own", bus_own, exp_bus ? 1 : 0);
      check("dqm", {dram_ldqm, dram_udqm}, exp_bus ? 2'b11 : 2'b00);
      check("ref_req", ref_req, (debt != 0) ? 1 : 0);
      check("ref_done", ref_done, exp_done ? 1 : 0);
      check("ref_ovf", ref_ovf, ovf ? 1 : 0);
      check("pins_fixed", {dram_cke, dram_cs_n, dram_ba}, 4'b1000);
      done_prev = exp_done;
    end
  end

  // driver tasks: all input changes land 2 time units after a falling edge
  task automatic step(input int k);
    repeat (k) begin
      @(negedge clk);
      #2;
    end
  endtask

  task automatic run_random(input int k);
    for (int i = 0; i < k; i++) begin
      ref_ack = ($urandom_range(0, 2) == 0);
      step(1);
    end
  endtask

  task automatic pulse_reset(input int k);
    reset = 1'b1;
    step(k);
    reset = 1'b0;
  endtask

  int target;
  int stale;

  initial begin
    reset   = 1'b1;
    ref_ack = 1'b0;
    step(3);
    reset = 1'b0;
    step(T_DONE + 20);
`ifdef SDRAM_AUTO_REFRESH_EN
    ref_ack = 1'b1;
    step(220);
    ref_ack = 1'b0;
    step(450);
    check("debt_saturated_req", ref_req, 1);
    check("ovf_set", ref_ovf, 1);
    ref_ack = 1'b1;
    for (int i = 0; i < 300 && ref_req; i++) step(1);
    check("req_fall", ref_req, 0);
    check("ovf_sticky", ref_ovf, 1);
    ref_ack = 1'b0;
    step(120);
    // Grant so the refresh ends exactly as the next interval fires.
    target = T_DONE + T_REFI * ((n - T_DONE) / T_REFI + 2);
    for (int i = 0; i < 200 && n < target - T_RBUSY - 2; i++) step(1);
    ref_ack = 1'b1;
    step(1);
    ref_ack = 1'b0;
    step(T_RBUSY + 3);
    check("coincide_req_held", ref_req, 1);
    run_random(300);
`else
    run_random(300);
    check("no_req_default", ref_req, 0);
`endif
    pulse_reset($urandom_range(1, 3));
    step(T_POWERUP + T_RP + 3);
    pulse_reset($urandom_range(1, 3));
    run_random(T_DONE + 30);
    for (int r = 0; r < 4; r++) begin
      run_random($urandom_range(1, T_DONE + 150));
      pulse_reset($urandom_range(1, 3));
    end
    run_random(T_DONE + 60);
    ref_ack = 1'b0;
    step(5);
    stale = 0;
    foreach (exp_q[i]) if (int'(exp_q[i][31:16]) <= n) stale++;
    check("sb_drain", stale, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
